led_panel_rx_capture: RTL and testbench
=======================================

// Module: led_panel_rx_capture
// PURPOSE
//  HUB75 panel-side receiver: the far end of led_display_driver_phy. Samples the panel pins
//  (bclk, rgb0/rgb1, latch, row address) on the system clock and rebuilds each row of pixels.
//  Streams each captured row to a frame-buffer write port.
//  Used for on-chip loopback self-test of the driver and as a bench-side panel monitor.
// PARAMETERS
//  NUM_ROW_PIXELS  32  panel rows; NUM_ROW_PIXELS/2 row addresses (scan is split top/bottom)
//  NUM_COL_PIXELS  64  pixels shifted in per row per half
//  SYNC_STAGES     2   synchroniser depth on every panel input (>=2)
// PORTS
//  clk_in         in   1                  system clock, 100 MHz; bclk must be <= clk_in/4
//  n_reset_in     in   1                  async active-low reset
//  bclk_in        in   1                  panel bit clock; data is sampled on its rising edge
//  rgb0_in        in   3                  top-half {r,g,b}
//  rgb1_in        in   3                  bottom-half {r,g,b}
//  latch_in       in   1                  row latch; its rising edge ends the row
//  addr_in        in   RA=$clog2(NUM_ROW_PIXELS/2)   row address, sampled at latch rise
//  err_clr_in     in   1                  clears all sticky error flags
//  wr_en_out      out  1                  frame-buffer write strobe
//  wr_addr_out    out  RA+$clog2(NUM_COL_PIXELS)     {row, col}
//  wr_data_out    out  6                  {rgb0, rgb1} for that column
//  frame_done_out out  1                  one-cycle pulse
//  frame_cnt_out  out  16                 frames captured; wraps at 0xFFFF -> 0
//  bit_cnt_err_out out 1                  sticky: latch arrived after != NUM_COL_PIXELS bclk edges
//  overrun_err_out out 1                  sticky: latch arrived while the previous row was still draining
//  frame_crc_out  out  16                 see CONFIGURATION
// BEHAVIOUR
//  - Reset: every output is 0 (frame_crc_out included). State IDLE, disarmed, all counters 0.
//  - All panel inputs pass through SYNC_STAGES flops.
//  - A rising edge on synced bclk (1-cycle strobe) shifts {rgb0,rgb1} into a 6*NUM_COL_PIXELS
//    shift register. The bit counter increments and saturates at 2*NUM_COL_PIXELS-1.
//  - First-shifted pixel = column NUM_COL_PIXELS-1; last-shifted pixel = column 0.
//  - Rising edge on synced latch:
//      disarmed -> set armed; no drain, no error check, bit counter cleared.
//      armed    -> flag bit_cnt_err if counter != NUM_COL_PIXELS.
//                  If state is IDLE: copy shift reg to hold reg, capture addr, go to DRAIN.
//                  If state is DRAIN: set overrun_err and drop this row (hold reg untouched).
//                  In both cases the bit counter clears.
//  - A bclk edge and a latch edge in the same cycle: the bclk data is shifted first and
//    counted, then the latch is processed.
//  - FSM: IDLE -> DRAIN on an accepted latch.
//    DRAIN issues one write per clk_in, col 0..NUM_COL_PIXELS-1, then returns to IDLE.
//    wr_en_out first asserts the cycle after the latch strobe.
//    Pin-to-first-write latency = SYNC_STAGES+2 clk_in cycles.
//  - Shifting of the next row continues during DRAIN; the hold reg double-buffers it.
//  - On the last write of row NUM_ROW_PIXELS/2-1: pulse frame_done_out and increment frame_cnt_out.
//    Rows need not arrive in order; only the last address triggers frame_done.
//  - err_clr_in clears the sticky flags. If clear and set occur in the same cycle, set wins.
//  - Asynchronous reset mid-row or mid-drain aborts the row. No partial write follows release;
//    the block re-arms on the next latch.
// CONFIGURATION
//  - Macro LED_RX_FRAME_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first)
//    runs over each wr_data_out zero-extended to 8 bits, in write order.
//    frame_crc_out loads the final value in the cycle frame_done_out pulses.
//    The running CRC then reinitialises to 0xFFFF.
//  - Macro not defined: no CRC logic is built and frame_crc_out is tied to 0.
// STRUCTURE
//  - Package led_display_pkg: rgb_t (3-bit packed r,g,b), pixel_pair_t {rgb_t top, bot},
//    rx_state_t enum {RX_IDLE, RX_DRAIN}, CRC16_POLY/CRC16_INIT constants.
//  - Sub-module led_panel_rx_sync: parameterised synchroniser plus rising-edge strobe,
//    instantiated for bclk and latch. Data and address go through sync only.
// TESTING
//  1. Reset, latch (arms), 64 bclk with col k = 3'(k),3'(~k), latch addr=5
//     -> 64 writes {5,k}, data matches, bit_cnt_err=0.
//  2. Send 63 bclk, then latch -> bit_cnt_err=1 and the row is still written.
//     Then err_clr -> flag returns to 0.
//  3. Second latch 20 clk after the first (drain unfinished) -> overrun_err=1,
//     the second row produces no writes, and the first row completes all 64 writes.
//  4. Full 16-row frame via led_display_driver_phy at BCLK_FREQ 25 MHz
//     -> one frame_done pulse, frame_cnt=1, 1024 writes matching the driver's source pattern.
//  5. Assert n_reset_in during write 30 of a drain -> outputs 0 immediately,
//     no writes after release until a latch arms and a full row follows.
//  6. With LED_RX_FRAME_CRC_EN, an all-zero frame -> frame_crc equals the reference model CRC
//     over 1024 zero bytes. Without the macro -> frame_crc_out == 0 throughout.

Source files
------------

// File: rtl/led_display_pkg.sv
// Shared types and CRC helper for the HUB75 panel-side capture path.
// The CRC helper is used only when LED_RX_FRAME_CRC_EN is defined.
package led_display_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef struct packed {
    rgb_t top;
    rgb_t bot;
  } pixel_pair_t;

  typedef enum logic {RX_IDLE, RX_DRAIN} rx_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // CRC-16-CCITT over one byte, MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/led_panel_rx_sync.sv
// Multi-flop synchroniser for one panel pin with a registered rising-edge strobe.
module led_panel_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic n_reset_in,
  input  logic d_in,
  output logic rise_out
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_in};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign rise_out = r_rise;

endmodule

// File: rtl/led_panel_rx_capture.sv
// HUB75 panel-side receiver: rebuilds each row from the panel pins and drains it to a
// frame-buffer write port. Optional frame CRC is built when LED_RX_FRAME_CRC_EN is defined.
module led_panel_rx_capture
  import led_display_pkg::*;
#(
  parameter int  NUM_ROW_PIXELS = 32,
  parameter int  NUM_COL_PIXELS = 64,
  parameter int  SYNC_STAGES    = 2,
  localparam int RA             = $clog2(NUM_ROW_PIXELS / 2),
  localparam int CA             = $clog2(NUM_COL_PIXELS)
) (
  input  logic          clk_in,
  input  logic          n_reset_in,
  input  logic          bclk_in,
  input  logic [2:0]    rgb0_in,
  input  logic [2:0]    rgb1_in,
  input  logic          latch_in,
  input  logic [RA-1:0] addr_in,
  input  logic          err_clr_in,
  output logic          wr_en_out,
  output logic [RA+CA-1:0] wr_addr_out,
  output logic [5:0]    wr_data_out,
  output logic          frame_done_out,
  output logic [15:0]   frame_cnt_out,
  output logic          bit_cnt_err_out,
  output logic          overrun_err_out,
  output logic [15:0]   frame_crc_out
);

  localparam int            SW      = 6 * NUM_COL_PIXELS;
  localparam int            CW      = $clog2(2 * NUM_COL_PIXELS);
  localparam logic [CW-1:0] CNT_MAX = CW'(2 * NUM_COL_PIXELS - 1);

  logic            w_bclk_rise;
  logic            w_latch_rise;
  logic [RA+5:0]   r_dsync [SYNC_STAGES+1];
  pixel_pair_t     w_pix;
  logic [RA-1:0]   w_addr;
  logic [SW-1:0]   r_shift, r_hold, w_shift_next;
  logic [CW-1:0]   r_bit_cnt, w_cnt_next;
  logic            r_armed;
  rx_state_t       r_state, w_state_next;
  logic [RA-1:0]   r_row;
  logic [CA-1:0]   r_col;
  logic            w_col_last, w_accept, w_overrun, w_cnt_bad, w_last_write;
  logic            r_bit_err, r_ovr_err, r_frame_done;
  logic [15:0]     r_frame_cnt;

  led_panel_rx_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .d_in(bclk_in), .rise_out(w_bclk_rise)
  );

  led_panel_rx_sync #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .d_in(latch_in), .rise_out(w_latch_rise)
  );

  // One extra stage beyond the synchroniser lines data up with the registered strobes
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      for (int i = 0; i <= SYNC_STAGES; i++) r_dsync[i] <= '0;
    end else begin
      r_dsync[0] <= {rgb0_in, rgb1_in, addr_in};
      for (int i = 1; i <= SYNC_STAGES; i++) r_dsync[i] <= r_dsync[i-1];
    end
  end

  assign w_pix  = pixel_pair_t'(r_dsync[SYNC_STAGES][RA +: 6]);
  assign w_addr = r_dsync[SYNC_STAGES][RA-1:0];

  // A same-cycle bclk edge is folded in before the latch looks at shift reg and count
  assign w_shift_next = w_bclk_rise ? {r_shift[SW-7:0], w_pix} : r_shift;
  assign w_cnt_next   = (w_bclk_rise && r_bit_cnt != CNT_MAX) ? r_bit_cnt + 1'b1 : r_bit_cnt;
  assign w_accept     = w_latch_rise & r_armed & (r_state == RX_IDLE);
  assign w_overrun    = w_latch_rise & r_armed & (r_state == RX_DRAIN);
  assign w_cnt_bad    = w_latch_rise & r_armed & (w_cnt_next != CW'(NUM_COL_PIXELS));
  assign w_col_last   = (r_col == CA'(NUM_COL_PIXELS - 1));
  assign w_last_write = wr_en_out & w_col_last & (r_row == RA'(NUM_ROW_PIXELS / 2 - 1));

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) r_state <= RX_IDLE;
    else             r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    wr_en_out    = 1'b0;
    wr_addr_out  = '0;
    wr_data_out  = '0;
    case (r_state)
      RX_IDLE:  if (w_accept) w_state_next = RX_DRAIN;
      RX_DRAIN: begin
        wr_en_out   = 1'b1;
        wr_addr_out = {r_row, r_col};
        wr_data_out = r_hold[6*r_col +: 6];
        if (w_col_last) w_state_next = RX_IDLE;
      end
      default:  w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_shift      <= '0;
      r_hold       <= '0;
      r_bit_cnt    <= '0;
      r_armed      <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_bit_err    <= 1'b0;
      r_ovr_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_latch_rise ? '0 : w_cnt_next;
      if (w_latch_rise) r_armed <= 1'b1;
      if (w_accept) begin
        r_hold <= w_shift_next;
        r_row  <= w_addr;
      end
      if (wr_en_out) r_col <= w_col_last ? '0 : r_col + 1'b1;
      r_bit_err    <= w_cnt_bad | (r_bit_err & ~err_clr_in);
      r_ovr_err    <= w_overrun | (r_ovr_err & ~err_clr_in);
      r_frame_done <= w_last_write;
      if (w_last_write) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_done_out  = r_frame_done;
  assign frame_cnt_out   = r_frame_cnt;
  assign bit_cnt_err_out = r_bit_err;
  assign overrun_err_out = r_ovr_err;

`ifdef LED_RX_FRAME_CRC_EN
  logic [15:0] r_crc, r_frame_crc, w_crc_next;

  assign w_crc_next = crc16_byte(r_crc, {2'b00, wr_data_out});

  // frame_crc_out becomes valid together with the frame_done_out pulse
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      r_crc       <= CRC16_INIT;
      r_frame_crc <= '0;
    end else if (wr_en_out) begin
      r_crc <= w_last_write ? CRC16_INIT : w_crc_next;
      if (w_last_write) r_frame_crc <= w_crc_next;
    end
  end

  assign frame_crc_out = r_frame_crc;
`else
  assign frame_crc_out = '0;
`endif

endmodule

// File: tb/tb_led_panel_rx_capture.sv
// Directed bench for led_panel_rx_capture: drives HUB75 pins at a 25 MHz bclk and
// checks the captured write stream, error flags, frame counting and frame CRC.
module tb_led_panel_rx_capture;

  logic        clk_in = 1'b0;
  logic        n_reset_in = 1'b0;
  logic        bclk_in = 1'b0;
  logic [2:0]  rgb0_in = '0;
  logic [2:0]  rgb1_in = '0;
  logic        latch_in = 1'b0;
  logic [3:0]  addr_in = '0;
  logic        err_clr_in = 1'b0;
  logic        wr_en_out;
  logic [9:0]  wr_addr_out;
  logic [5:0]  wr_data_out;
  logic        frame_done_out;
  logic [15:0] frame_cnt_out;
  logic        bit_cnt_err_out;
  logic        overrun_err_out;
  logic [15:0] frame_crc_out;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  logic [15:0] wq[$];

  led_panel_rx_capture dut (
    .clk_in(clk_in), .n_reset_in(n_reset_in), .bclk_in(bclk_in),
    .rgb0_in(rgb0_in), .rgb1_in(rgb1_in), .latch_in(latch_in), .addr_in(addr_in),
    .err_clr_in(err_clr_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .frame_done_out(frame_done_out), .frame_cnt_out(frame_cnt_out),
    .bit_cnt_err_out(bit_cnt_err_out), .overrun_err_out(overrun_err_out),
    .frame_crc_out(frame_crc_out)
  );

  always #5 clk_in = ~clk_in;

  // Write and frame_done recorder, sampled on the inactive edge
  always @(negedge clk_in) begin
    if (wr_en_out) wq.push_back({wr_addr_out, wr_data_out});
    if (frame_done_out) fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Stimulus pattern per mode: {rgb0, rgb1} for row r, column k
  function automatic logic [5:0] pix(input int mode, input int r, input int k);
    case (mode)
      0:       return {3'(k), 3'(~k)};
      1:       return {3'(k + 1), 3'(k >> 3)};
      2:       return {3'(k + r), 3'(k ^ r)};
      default: return 6'd0;
    endcase
  endfunction

  task automatic send_pixels(input int mode, input int r, input int n);
    logic [5:0] p;
    for (int k = n - 1; k >= 0; k--) begin
      p = pix(mode, r, k);
      bclk_in = 1'b0;
      rgb0_in = p[5:3];
      rgb1_in = p[2:0];
      tick(2);
      bclk_in = 1'b1;
      tick(2);
    end
    bclk_in = 1'b0;
  endtask

  // Latch pulse; lat = ticks from latch rise to first observed wr_en (-1 if none in 8)
  task automatic latch_row(input logic [3:0] a, output int lat);
    addr_in = a;
    tick(2);
    latch_in = 1'b1;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      tick(1);
      if (n == 2) latch_in = 1'b0;
      if (wr_en_out && lat < 0) lat = n;
    end
    $display("latch addr=%0d first_write_after=%0d", a, lat);
  endtask

  task automatic check_row(input string tag, input int mode, input int r, input int base);
    logic [15:0] exp;
    for (int c = 0; c < 64; c++) begin
      exp = {4'(r), 6'(c), pix(mode, r, c)};
      if (base + c < wq.size()) check_eq(tag, 32'(wq[base + c]), 32'(exp));
    end
  endtask

`ifdef LED_RX_FRAME_CRC_EN
  function automatic logic [15:0] crc_zero_ref(input int nbytes);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nbytes * 8; i++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction
`endif

  initial begin
    int lat;
    int seen;

    // Reset state
    tick(3);
    check_eq("rst_wr_en", 32'(wr_en_out), 0);
    check_eq("rst_wr_addr", 32'(wr_addr_out), 0);
    check_eq("rst_wr_data", 32'(wr_data_out), 0);
    check_eq("rst_frame_done", 32'(frame_done_out), 0);
    check_eq("rst_frame_cnt", 32'(frame_cnt_out), 0);
    check_eq("rst_errs", 32'({bit_cnt_err_out, overrun_err_out}), 0);
    check_eq("rst_crc", 32'(frame_crc_out), 0);
    n_reset_in = 1'b1;
    tick(3);

    // 1: arm, full row to addr 5
    latch_row(4'd0, lat);
    tick(20);
    check_eq("t1_arm_no_write", 32'(wq.size()), 0);
    send_pixels(0, 0, 64);
    latch_row(4'd5, lat);
    check_eq("t1_latency", 32'(lat), 4);
    tick(80);
    check_eq("t1_count", 32'(wq.size()), 64);
    check_row("t1_wr", 0, 5, 0);
    check_eq("t1_bit_err", 32'(bit_cnt_err_out), 0);
    check_eq("t1_ovr_err", 32'(overrun_err_out), 0);
    wq.delete();

    // 2: short row still written, flag sticky until cleared
    send_pixels(0, 0, 63);
    latch_row(4'd2, lat);
    tick(80);
    check_eq("t2_bit_err", 32'(bit_cnt_err_out), 1);
    check_eq("t2_count", 32'(wq.size()), 64);
    if (wq.size() > 0) check_eq("t2_first_addr", 32'(wq[0][15:6]), 32'({4'd2, 6'd0}));
    err_clr_in = 1'b1;
    tick(1);
    err_clr_in = 1'b0;
    tick(1);
    check_eq("t2_cleared", 32'(bit_cnt_err_out), 0);
    wq.delete();

    // 3: second latch 20 clk into the drain is dropped
    send_pixels(1, 0, 64);
    addr_in = 4'd7;
    tick(2);
    latch_in = 1'b1;
    tick(2);
    latch_in = 1'b0;
    tick(18);
    addr_in = 4'd9;
    latch_in = 1'b1;
    tick(2);
    latch_in = 1'b0;
    tick(100);
    check_eq("t3_ovr_err", 32'(overrun_err_out), 1);
    check_eq("t3_bit_err", 32'(bit_cnt_err_out), 1);
    check_eq("t3_count", 32'(wq.size()), 64);
    check_row("t3_wr", 1, 7, 0);
    wq.delete();

    // Clear with simultaneous set: set wins for that cycle
    err_clr_in = 1'b1;
    tick(1);
    check_eq("clr_both", 32'({bit_cnt_err_out, overrun_err_out}), 0);
    addr_in = 4'd1;
    tick(2);
    latch_in = 1'b1;
    seen = 0;
    for (int n = 1; n <= 10; n++) begin
      tick(1);
      if (n == 2) latch_in = 1'b0;
      if (bit_cnt_err_out) seen = 1;
    end
    check_eq("set_wins", 32'(seen), 1);
    err_clr_in = 1'b0;
    tick(80);
    check_eq("set_wins_after", 32'(bit_cnt_err_out), 0);
    wq.delete();

    // 4: full 16-row frame
    for (int r = 0; r < 16; r++) begin
      send_pixels(2, r, 64);
      latch_row(4'(r), lat);
    end
    tick(100);
    check_eq("t4_frame_done", 32'(fd_cnt), 1);
    check_eq("t4_frame_cnt", 32'(frame_cnt_out), 1);
    check_eq("t4_count", 32'(wq.size()), 1024);
    for (int r = 0; r < 16; r++) check_row("t4_wr", 2, r, r * 64);
    check_eq("t4_errs", 32'({bit_cnt_err_out, overrun_err_out}), 0);
    wq.delete();

    // 6: all-zero frame CRC
    for (int r = 0; r < 16; r++) begin
      send_pixels(3, r, 64);
      latch_row(4'(r), lat);
    end
    tick(100);
    check_eq("t6_frame_done", 32'(fd_cnt), 2);
    check_eq("t6_frame_cnt", 32'(frame_cnt_out), 2);
    check_eq("t6_count", 32'(wq.size()), 1024);
`ifdef LED_RX_FRAME_CRC_EN
    check_eq("t6_crc", 32'(frame_crc_out), 32'(crc_zero_ref(1024)));
`else
    check_eq("t6_crc_off", 32'(frame_crc_out), 0);
`endif
    wq.delete();

    // 5: reset during write 30 of a drain
    send_pixels(0, 0, 64);
    latch_row(4'd3, lat);
    seen = 0;
    for (int n = 0; n < 200 && seen == 0; n++) begin
      if (wq.size() >= 30) seen = 1;
      else tick(1);
    end
    check_eq("t5_reach_write30", 32'(seen), 1);
    n_reset_in = 1'b0;
    #1;
    check_eq("t5_rst_wr_en", 32'(wr_en_out), 0);
    check_eq("t5_rst_frame_cnt", 32'(frame_cnt_out), 0);
    check_eq("t5_rst_crc", 32'(frame_crc_out), 0);
    tick(3);
    n_reset_in = 1'b1;
    wq.delete();
    tick(100);
    check_eq("t5_no_write_after", 32'(wq.size()), 0);
    latch_row(4'd4, lat);
    tick(50);
    check_eq("t5_rearm_no_write", 32'(wq.size()), 0);
    send_pixels(0, 0, 64);
    latch_row(4'd4, lat);
    tick(80);
    check_eq("t5_count", 32'(wq.size()), 64);
    check_row("t5_wr", 0, 4, 0);
    check_eq("t5_bit_err", 32'(bit_cnt_err_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
